// File: rtl/calc_pkg.sv
// Shared keypad types: FSM state encoding, key classes, operator indices and the keymap.
package calc_pkg;

  typedef enum logic [2:0] {
    SCAN     = 3'd0,
    DEBOUNCE = 3'd1,
    PRESSED  = 3'd2,
    HELD     = 3'd3,
    RELEASE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    KC_DIG  = 2'd0,
    KC_OP   = 2'd1,
    KC_BKSP = 2'd2,
    KC_CLR  = 2'd3
  } key_class_e;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_DIV    = 4'd3;
  localparam logic [3:0] ROWS_IDLE = 4'hF;

  typedef struct packed {
    key_class_e kclass;
    logic [3:0] code;
  } key_t;

  // Physical layout: r0=1 2 3 A, r1=4 5 6 B, r2=7 8 9 C, r3=* 0 # D
  function automatic key_t keymap(input logic [1:0] row, input logic [1:0] col);
    key_t k;
    case ({row, col})
      4'h0:    k = '{KC_DIG,  4'd1};
      4'h1:    k = '{KC_DIG,  4'd2};
      4'h2:    k = '{KC_DIG,  4'd3};
      4'h3:    k = '{KC_OP,   OP_ADD};
      4'h4:    k = '{KC_DIG,  4'd4};
      4'h5:    k = '{KC_DIG,  4'd5};
      4'h6:    k = '{KC_DIG,  4'd6};
      4'h7:    k = '{KC_OP,   OP_SUB};
      4'h8:    k = '{KC_DIG,  4'd7};
      4'h9:    k = '{KC_DIG,  4'd8};
      4'hA:    k = '{KC_DIG,  4'd9};
      4'hB:    k = '{KC_OP,   OP_MUL};
      4'hC:    k = '{KC_BKSP, 4'd0};
      4'hD:    k = '{KC_DIG,  4'd0};
      4'hE:    k = '{KC_CLR,  4'd0};
      4'hF:    k = '{KC_OP,   OP_DIV};
      default: k = '{KC_DIG,  4'd0};
    endcase
    return k;
  endfunction

  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous active-low keypad rows; idles at all-high.
module keypad_sync
  import calc_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [3:0] i_row,
  output logic [3:0] o_row_sync
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_meta <= ROWS_IDLE;
      r_sync <= ROWS_IDLE;
    end else begin
      r_meta <= i_row;
      r_sync <= r_meta;
    end
  end

  assign o_row_sync = r_sync;

endmodule

// File: rtl/keypad_decoder.sv
// 4x4 keypad scanner/debouncer emitting one class pulse per accepted press.
// Optional `KEY_REPEAT_EN: auto-repeat of backspace while '*' is held.
module keypad_decoder
  import calc_pkg::*;
#(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_RATE     = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       dig_pulse,
  output logic       op_pulse,
  output logic       bksp_pulse,
  output logic       clr_pulse,
  output logic [3:0] key_code
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [3:0]    w_rs;
  state_e        r_state;
  state_e        w_next_state;
  logic [SW-1:0] r_scan_cnt;
  logic [DW-1:0] r_db_cnt;
  logic [1:0]    r_col;
  logic [1:0]    r_row;
  logic [3:0]    r_col_out;
  logic          r_dig;
  logic          r_op;
  logic          r_bksp;
  logic          r_clr;
  logic [3:0]    r_key_code;
  logic          w_row_low;
  logic          w_scan_last;
  logic          w_db_last;
  logic          w_rep_fire;
  key_t          w_key;

  keypad_sync u_sync (
    .i_clock    (clock),
    .i_reset    (reset),
    .i_row      (row_in),
    .o_row_sync (w_rs)
  );

  assign w_row_low   = ~w_rs[r_row];
  assign w_scan_last = (r_scan_cnt == SW'(SCAN_DIV - 1));
  assign w_db_last   = (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign w_key       = keymap(r_row, r_col);

  always_ff @(posedge clock) begin
    if (reset) r_state <= SCAN;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SCAN:     if (w_scan_last && (w_rs != ROWS_IDLE)) w_next_state = DEBOUNCE;
                else                                    w_next_state = SCAN;
      DEBOUNCE: if (!w_row_low)     w_next_state = SCAN;
                else if (w_db_last) w_next_state = PRESSED;
                else                w_next_state = DEBOUNCE;
      PRESSED:  w_next_state = HELD;
      HELD:     if (!w_row_low) w_next_state = RELEASE;
                else            w_next_state = HELD;
      RELEASE:  if (w_row_low)      w_next_state = HELD;
                else if (w_db_last) w_next_state = SCAN;
                else                w_next_state = RELEASE;
      default:  w_next_state = SCAN;
    endcase
  end

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(REP_MAX + 1);

  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_phase;

  // First repeat waits REPEAT_DELAY after PRESSED, later ones REPEAT_RATE after the previous pulse
  assign w_rep_fire = (r_state == HELD) && w_row_low && (w_key.kclass == KC_BKSP) &&
                      (r_rep_cnt == (r_rep_phase ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_next_state == PRESSED) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
    end else if ((r_state == HELD) && (w_next_state == RELEASE)) begin
      r_rep_cnt   <= '0;
    end else if (w_rep_fire) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b1;
    end else if (((r_state == HELD) || (r_state == PRESSED)) && (r_rep_cnt != RW'(REP_MAX))) begin
      r_rep_cnt   <= r_rep_cnt + 1'b1;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_db_cnt   <= '0;
      r_col      <= 2'd0;
      r_row      <= 2'd0;
      r_col_out  <= 4'b1110;
      r_dig      <= 1'b0;
      r_op       <= 1'b0;
      r_bksp     <= 1'b0;
      r_clr      <= 1'b0;
      r_key_code <= 4'd0;
    end else begin
      r_dig  <= 1'b0;
      r_op   <= 1'b0;
      r_bksp <= 1'b0;
      r_clr  <= 1'b0;
      case (r_state)
        SCAN: begin
          if (w_scan_last) begin
            r_scan_cnt <= '0;
            r_db_cnt   <= '0;
            if (w_rs != ROWS_IDLE) begin
              r_row <= lowest_low(w_rs);
            end else begin
              r_col     <= r_col + 2'd1;
              r_col_out <= {r_col_out[2:0], r_col_out[3]};
            end
          end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!w_row_low) begin
            r_db_cnt   <= '0;
            r_scan_cnt <= '0;
            r_col      <= r_col + 2'd1;
            r_col_out  <= {r_col_out[2:0], r_col_out[3]};
          end else if (w_db_last) begin
            r_db_cnt   <= '0;
            r_key_code <= w_key.code;
            case (w_key.kclass)
              KC_DIG:  r_dig  <= 1'b1;
              KC_OP:   r_op   <= 1'b1;
              KC_BKSP: r_bksp <= 1'b1;
              KC_CLR:  r_clr  <= 1'b1;
              default: r_dig  <= 1'b0;
            endcase
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end
        PRESSED: r_db_cnt <= '0;
        HELD: begin
          r_db_cnt <= '0;
          if (w_rep_fire) r_bksp <= 1'b1;
        end
        RELEASE: begin
          if (w_row_low) begin
            r_db_cnt <= '0;
          end else if (w_db_last) begin
            r_db_cnt   <= '0;
            r_scan_cnt <= '0;
            r_col      <= r_col + 2'd1;
            r_col_out  <= {r_col_out[2:0], r_col_out[3]};
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end
        default: r_db_cnt <= '0;
      endcase
    end
  end

  assign col_out    = r_col_out;
  assign dig_pulse  = r_dig;
  assign op_pulse   = r_op;
  assign bksp_pulse = r_bksp;
  assign clr_pulse  = r_clr;
  assign key_code   = r_key_code;

endmodule

// File: tb/tb_keypad_decoder.sv
// Self-checking bench for keypad_decoder: physical keypad model plus an event-level reference of expected presses.
module tb_keypad_decoder;

  localparam int SD = 4;
  localparam int DB = 8;
  localparam int RD = 40;
  localparam int RR = 10;
  localparam int DETECT_RUN = SD + DB + 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       dig_pulse;
  logic       op_pulse;
  logic       bksp_pulse;
  logic       clr_pulse;
  logic [3:0] key_code;
  logic [15:0] key_down = 16'h0000;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int cyc;
    int kind;
    int code;
    int run;
  } ev_t;
  ev_t evq[$];

  int         cyc = 0;
  int         run = 0;
  logic [3:0] last_col = 4'hF;
  logic       prev_pulse = 1'b0;

  keypad_decoder #(
    .SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clock(clock), .reset(reset), .row_in(row_in), .col_out(col_out),
    .dig_pulse(dig_pulse), .op_pulse(op_pulse), .bksp_pulse(bksp_pulse),
    .clr_pulse(clr_pulse), .key_code(key_code)
  );

  always #5 clock = ~clock;

  // A pressed key shorts its row to its column while that column is driven low
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // kind: 0 digit, 1 operator, 2 backspace, 3 clear
  task automatic model(input int k, output int kind, output int code);
    int row, col;
    row = k / 4;
    col = k % 4;
    code = 0;
    if (col == 3) begin
      kind = 1; code = row;
    end else if (row == 3) begin
      kind = (col == 0) ? 2 : (col == 1) ? 0 : 3;
    end else begin
      kind = 0; code = row * 3 + col + 1;
    end
  endtask

  task automatic sample();
    logic [3:0] p;
    ev_t e;
    cyc++;
    if (reset) begin
      run = 0;
      last_col = 4'hF;
      prev_pulse = 1'b0;
    end else begin
      if (run != 0 && col_out == last_col) run++;
      else run = 1;
      last_col = col_out;
      p = {clr_pulse, bksp_pulse, op_pulse, dig_pulse};
      if (p != 4'b0000) begin
        n_tests++;
        if ($countones(p) != 1) begin
          n_fail++;
          $display("FAIL exclusive: pulses=%b required one-hot", p);
        end
        n_tests++;
        if (prev_pulse) begin
          n_fail++;
          $display("FAIL back_to_back: pulse at cycle %0d follows a pulse, required a gap", cyc);
        end
        e.cyc  = cyc;
        e.kind = dig_pulse ? 0 : op_pulse ? 1 : bksp_pulse ? 2 : 3;
        e.code = int'(key_code);
        e.run  = run;
        evq.push_back(e);
      end
      prev_pulse = (p != 4'b0000);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      sample();
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_events(input int n, input int budget, input string name);
    int i;
    i = 0;
    while (evq.size() < n && i < budget) begin
      step(1);
      i++;
    end
    n_tests++;
    if (evq.size() < n) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d events, required %0d within %0d cycles", name, evq.size(), n, budget);
    end
  endtask

  task automatic check_one(input string name, input int exp_kind, input int exp_code, input logic chk_run);
    n_tests++;
    if (evq.size() != 1) begin
      n_fail++;
      $display("FAIL %s_count: got %0d pulses, required 1", name, evq.size());
    end else begin
      n_tests++;
      if (evq[0].kind != exp_kind) begin
        n_fail++;
        $display("FAIL %s_kind: got %0d, required %0d", name, evq[0].kind, exp_kind);
      end
      if (exp_kind < 2) begin
        n_tests++;
        if (evq[0].code != exp_code) begin
          n_fail++;
          $display("FAIL %s_code: got %0d, required %0d", name, evq[0].code, exp_code);
        end
      end
      if (chk_run) begin
        n_tests++;
        if (evq[0].run != DETECT_RUN) begin
          n_fail++;
          $display("FAIL %s_latency: column frozen %0d cycles at pulse, required %0d", name, evq[0].run, DETECT_RUN);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] one;
    logic [3:0] exp;
    one = 4'b0001;
    key_down = 16'h0000;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    n_tests++;
    if ({dig_pulse, op_pulse, bksp_pulse, clr_pulse, key_code} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 00000000", {dig_pulse, op_pulse, bksp_pulse, clr_pulse, key_code});
    end
    for (int k = 0; k < 16; k++) begin
      exp = ~(one << ((k / 4) % 4));
      n_tests++;
      if (col_out !== exp) begin
        n_fail++;
        $display("FAIL scan_col[%0d]: got %b, required %b", k, col_out, exp);
      end
      step(1);
    end
  endtask

  task automatic test_idle();
    evq.delete();
    step(200);
    n_tests++;
    if (evq.size() != 0) begin
      n_fail++;
      $display("FAIL idle_pulses: got %0d, required 0", evq.size());
    end
  endtask

  task automatic test_hold_5();
    evq.delete();
    key_down[5] = 1'b1;
    step(100);
    check_one("hold5", 0, 5, 1'b1);
    n_tests++;
    if (col_out !== 4'b1101) begin
      n_fail++;
      $display("FAIL hold5_col: got %b, required 1101", col_out);
    end
    key_down[5] = 1'b0;
    step(40);
    check_one("hold5_after_release", 0, 5, 1'b1);
  endtask

  task automatic test_bounce();
    evq.delete();
    repeat (3) begin
      key_down[5] = 1'b1; step(3);
      key_down[5] = 1'b0; step(2);
    end
    key_down[5] = 1'b1;
    step(60);
    repeat (3) begin
      key_down[5] = 1'b0; step(5);
      key_down[5] = 1'b1; step(3);
    end
    key_down[5] = 1'b0;
    step(40);
    check_one("bounce5", 0, 5, 1'b1);
  endtask

  task automatic test_rollover();
    int rel_cyc;
    evq.delete();
    key_down[11] = 1'b1;
    step(40);
    key_down[0] = 1'b1;
    step(40);
    check_one("rollover_C", 1, 2, 1'b1);
    key_down[11] = 1'b0;
    rel_cyc = cyc;
    wait_events(2, 60, "rollover_1");
    if (evq.size() >= 2) begin
      n_tests++;
      if (evq[1].kind != 0 || evq[1].code != 1) begin
        n_fail++;
        $display("FAIL rollover_second: got kind %0d code %0d, required kind 0 code 1", evq[1].kind, evq[1].code);
      end
      n_tests++;
      if (evq[1].cyc - rel_cyc < 20) begin
        n_fail++;
        $display("FAIL rollover_early: got %0d cycles after C release, required >= 20", evq[1].cyc - rel_cyc);
      end
    end
    key_down[0] = 1'b0;
    step(40);
  endtask

  task automatic test_bksp_clr();
    evq.delete();
    key_down[12] = 1'b1; step(40);
    key_down[12] = 1'b0; step(40);
    key_down[14] = 1'b1; step(40);
    key_down[14] = 1'b0; step(40);
    n_tests++;
    if (evq.size() != 2) begin
      n_fail++;
      $display("FAIL bksp_clr_count: got %0d, required 2", evq.size());
    end else begin
      n_tests++;
      if (evq[0].kind != 2 || evq[1].kind != 3) begin
        n_fail++;
        $display("FAIL bksp_clr_order: got kinds %0d,%0d, required 2,3", evq[0].kind, evq[1].kind);
      end
    end
  endtask

  task automatic test_reset_mid(input logic hold_through);
    int i;
    evq.delete();
    key_down[8] = 1'b1;
    i = 0;
    while (!(run >= 5 && col_out == 4'b1110) && i < 100) begin
      step(1);
      i++;
    end
    n_tests++;
    if (i >= 100) begin
      n_fail++;
      $display("FAIL reset_mid_detect: got no frozen column in 100 cycles, required freeze at 1110");
    end
    reset = 1'b1;
    if (!hold_through) key_down[8] = 1'b0;
    step(2);
    reset = 1'b0;
    n_tests++;
    if (col_out !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_mid_col: got %b, required 1110", col_out);
    end
    if (hold_through) begin
      wait_events(1, 60, "reset_afresh");
      step(5);
      check_one("reset_afresh", 0, 7, 1'b1);
      key_down[8] = 1'b0;
      step(40);
    end else begin
      step(40);
      n_tests++;
      if (evq.size() != 0) begin
        n_fail++;
        $display("FAIL reset_mid_pulse: got %0d pulses, required 0", evq.size());
      end
    end
  endtask

  task automatic test_repeat();
    int exp_off[$];
    int base;
`ifdef KEY_REPEAT_EN
    exp_off = '{0, RD, RD + RR, RD + 2*RR, RD + 3*RR};
`else
    exp_off = '{0};
`endif
    evq.delete();
    key_down[12] = 1'b1;
    wait_events(1, 60, "repeat_first");
    base = (evq.size() > 0) ? evq[0].cyc : cyc;
    step(75);
    key_down[12] = 1'b0;
    step(30);
    n_tests++;
    if (evq.size() != exp_off.size()) begin
      n_fail++;
      $display("FAIL repeat_count: got %0d bksp pulses, required %0d", evq.size(), exp_off.size());
    end else begin
      foreach (exp_off[j]) begin
        n_tests++;
        if (evq[j].kind != 2 || evq[j].cyc - base != exp_off[j]) begin
          n_fail++;
          $display("FAIL repeat_time[%0d]: got kind %0d at +%0d, required kind 2 at +%0d", j, evq[j].kind, evq[j].cyc - base, exp_off[j]);
        end
      end
    end
  endtask

  task automatic test_random_keys();
    int k, hold, kind, code;
    for (int n = 0; n < 8; n++) begin
      k = int'($urandom_range(15, 0));
      hold = int'($urandom_range(36, 30));
      model(k, kind, code);
      evq.delete();
      key_down[k] = 1'b1;
      step(hold);
      key_down[k] = 1'b0;
      step(30);
      check_one($sformatf("random_key%0d", k), kind, code, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_hold_5();
    test_bounce();
    test_rollover();
    test_bksp_clr();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_repeat();
    test_random_keys();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
